// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall/flush controller: latch enables and clears, halt drain, perf counters.
// Optional feature: define PIPELINE_CTRL_PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_ctrl #(
    parameter int CNT_W = 16,
    parameter int DRAIN = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             ex_memop,
    input  logic             idex_memren,
    input  logic [4:0]       idex_regdest,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             br_mispredict,
    input  logic             jump,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halt_out,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DCW = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);

    typedef enum logic [2:0] {
        S_RUN    = 3'd0,
        S_DWAIT  = 3'd1,
        S_FLUSH  = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [DCW-1:0] r_drain_cnt;
    logic [DCW-1:0] w_drain_next;
    logic           r_lu_block;
    logic           w_lu_block_next;
    logic           w_adv;
    logic           w_load_use;

    assign w_adv      = ihit & (~ex_memop | dhit);
    assign w_load_use = idex_memren & (idex_regdest != 5'd0) &
                        ((idex_regdest == ifid_rs) | (idex_regdest == ifid_rt));

    assign state    = r_state;
    assign halt_out = (r_state == S_HALTED);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state     <= S_RUN;
            r_drain_cnt <= '0;
            r_lu_block  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_next;
            r_lu_block  <= w_lu_block_next;
        end
    end

    always_comb begin
        pc_en           = 1'b0;
        ifid_en         = 1'b0;
        idex_en         = 1'b0;
        exmem_en        = 1'b0;
        memwb_en        = 1'b0;
        ifid_flush      = 1'b0;
        idex_flush      = 1'b0;
        exmem_flush     = 1'b0;
        w_state_next    = r_state;
        w_drain_next    = r_drain_cnt;
        w_lu_block_next = r_lu_block;

        case (r_state)
            S_RUN, S_DWAIT, S_FLUSH: begin
                if (!w_adv) begin
                    // FLUSH holds on a stall; only RUN/DWAIT move to DWAIT on a data miss.
                    if ((r_state != S_FLUSH) && ex_memop && !dhit) begin
                        w_state_next = S_DWAIT;
                    end
                end else begin
                    pc_en           = 1'b1;
                    ifid_en         = 1'b1;
                    idex_en         = 1'b1;
                    exmem_en        = 1'b1;
                    memwb_en        = 1'b1;
                    w_state_next    = S_RUN;
                    w_lu_block_next = 1'b0;
                    if (halt_mem) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_en     = 1'b0;
                        ifid_flush   = 1'b1;
                        idex_flush   = 1'b1;
                        exmem_flush  = 1'b1;
                        w_drain_next = DCW'(DRAIN);
                        w_state_next = S_DRAIN;
                    end else if (br_mispredict) begin
                        ifid_flush   = 1'b1;
                        idex_flush   = 1'b1;
                        exmem_flush  = 1'b1;
                        w_state_next = S_FLUSH;
                    end else if (w_load_use && !r_lu_block && (r_state != S_FLUSH)) begin
                        // Bubble into ID/EX once; the block flag stops a re-stall on held inputs.
                        pc_en           = 1'b0;
                        ifid_en         = 1'b0;
                        idex_flush      = 1'b1;
                        w_lu_block_next = 1'b1;
                    end else if (jump) begin
                        ifid_flush = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                memwb_en     = 1'b1;
                w_drain_next = r_drain_cnt - DCW'(1);
                if (r_drain_cnt <= DCW'(1)) begin
                    w_state_next = S_HALTED;
                end
            end
            S_HALTED: begin
                w_state_next = S_HALTED;
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_evt;
    logic             w_flush_evt;

    assign w_stall_evt = ~pc_en & (r_state != S_HALTED);
    assign w_flush_evt = ifid_flush | idex_flush | exmem_flush;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Table-driven bench for pipeline_ctrl: per-cycle vectors plus reset corner sequences.
module tb_pipeline_ctrl;

    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             ihit, dhit, ex_memop, idex_memren;
    logic [4:0]       idex_regdest, ifid_rs, ifid_rt;
    logic             br_mispredict, jump, halt_mem;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, exmem_flush, halt_out;
    logic [2:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    pipeline_ctrl #(.CNT_W(CNT_W), .DRAIN(2)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .ex_memop(ex_memop),
        .idex_memren(idex_memren), .idex_regdest(idex_regdest),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .br_mispredict(br_mispredict),
        .jump(jump), .halt_mem(halt_mem), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .halt_out(halt_out), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       ihit, dhit, exm, mr;
        logic [4:0] rd, rs, rt;
        logic       bm, jmp, hlt;
        logic [2:0] st;
        logic [4:0] en;   // {pc, ifid, idex, exmem, memwb}
        logic [2:0] fl;   // {ifid, idex, exmem}
        logic       halt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int n, input logic i_ihit, i_dhit, i_exm, i_mr,
                       input logic [4:0] i_rd, i_rs, i_rt,
                       input logic i_bm, i_jmp, i_hlt,
                       input logic [2:0] e_st, input logic [4:0] e_en,
                       input logic [2:0] e_fl, input logic e_halt);
        vec_t v;
        v.ihit = i_ihit; v.dhit = i_dhit; v.exm = i_exm; v.mr = i_mr;
        v.rd = i_rd; v.rs = i_rs; v.rt = i_rt;
        v.bm = i_bm; v.jmp = i_jmp; v.hlt = i_hlt;
        v.st = e_st; v.en = e_en; v.fl = e_fl; v.halt = e_halt;
        for (int k = 0; k < n; k++) vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic apply(input vec_t v);
        ihit = v.ihit; dhit = v.dhit; ex_memop = v.exm; idex_memren = v.mr;
        idex_regdest = v.rd; ifid_rs = v.rs; ifid_rt = v.rt;
        br_mispredict = v.bm; jump = v.jmp; halt_mem = v.hlt;
    endtask

    task automatic chk_counters(input string tag);
`ifdef PIPELINE_CTRL_PERF_CNT_EN
        chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
        chk({tag, " flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
`else
        chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'd0);
        chk({tag, " flush_cnt"}, 32'(flush_cnt), 32'd0);
`endif
    endtask

    initial begin
        vec_t nv;
        //  n  ih dh ex mr rd rs rt bm jp hl | st en        fl      halt
        add(10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 5'b11111, 3'b000, 0);
        add(1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 5'b00000, 3'b000, 0);
        add(1,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 5'b00000, 3'b000, 0);
        add(2,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 5'b00000, 3'b000, 0);
        add(1,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 5'b11111, 3'b000, 0);
        add(1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 5'b11111, 3'b000, 0);
        add(1,  1, 0, 0, 1, 5, 0, 5, 0, 0, 0,  0, 5'b00111, 3'b010, 0);
        add(1,  1, 0, 0, 1, 5, 0, 5, 0, 0, 0,  0, 5'b11111, 3'b000, 0);
        add(1,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 5'b11111, 3'b000, 0);
        add(1,  1, 0, 0, 1, 7, 7, 0, 0, 0, 0,  0, 5'b00111, 3'b010, 0);
        add(1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 5'b11111, 3'b000, 0);
        add(1,  1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 5'b11111, 3'b100, 0);
        add(1,  1, 0, 0, 1, 3, 3, 0, 1, 0, 0,  0, 5'b11111, 3'b111, 0);
        add(1,  1, 0, 0, 1, 3, 3, 0, 0, 0, 0,  2, 5'b11111, 3'b000, 0);
        add(1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 5'b11111, 3'b000, 0);
        add(1,  1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 5'b11111, 3'b111, 0);
        add(1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 5'b00000, 3'b000, 0);
        add(1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 5'b11111, 3'b000, 0);
        add(1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 5'b11111, 3'b000, 0);
        add(1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 5'b00000, 3'b000, 0);
        add(1,  1, 0, 0, 0, 0, 0, 0, 1, 1, 1,  0, 5'b00001, 3'b111, 0);
        add(1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  3, 5'b00001, 3'b000, 0);
        add(1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  3, 5'b00001, 3'b000, 0);
        add(2,  1, 0, 0, 0, 0, 0, 0, 1, 0, 1,  4, 5'b00000, 3'b000, 1);

        nv.ihit = 1; nv.dhit = 0; nv.exm = 0; nv.mr = 0; nv.rd = 0; nv.rs = 0; nv.rt = 0;
        nv.bm = 0; nv.jmp = 0; nv.hlt = 0;
        nv.st = 0; nv.en = 5'b11111; nv.fl = 0; nv.halt = 0;

        nRST = 1'b0;
        apply(nv);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset state", 32'(state), 32'd0);
        chk("reset enables", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'h1f);
        chk("reset flushes", 32'({ifid_flush, idex_flush, exmem_flush}), 32'd0);
        chk("reset halt_out", 32'(halt_out), 32'd0);
        chk_counters("reset");
        nRST = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge CLK);
            apply(vq[i]);
            #1;
            chk($sformatf("vec%0d state", i), 32'(state), 32'(vq[i].st));
            chk($sformatf("vec%0d enables", i),
                32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(vq[i].en));
            chk($sformatf("vec%0d flushes", i),
                32'({ifid_flush, idex_flush, exmem_flush}), 32'(vq[i].fl));
            chk($sformatf("vec%0d halt_out", i), 32'(halt_out), 32'(vq[i].halt));
            chk_counters($sformatf("vec%0d", i));
            $display("vec %0d state=%0d en=%b fl=%b halt=%b", i, state,
                     {pc_en, ifid_en, idex_en, exmem_en, memwb_en},
                     {ifid_flush, idex_flush, exmem_flush}, halt_out);
            if (vq[i].en[4] == 1'b0 && vq[i].st != 3'd4) exp_stall++;
            if (vq[i].fl != 3'b000) exp_flush++;
        end

        // Reset out of HALTED
        @(negedge CLK);
        nRST = 1'b0;
        apply(nv);
        @(posedge CLK);
        #1;
        exp_stall = 0;
        exp_flush = 0;
        chk("halted reset state", 32'(state), 32'd0);
        chk("halted reset halt_out", 32'(halt_out), 32'd0);
        chk("halted reset pc_en", 32'(pc_en), 32'd1);
        chk_counters("halted reset");
        $display("reset from HALTED state=%0d halt=%b", state, halt_out);

        // Reset in the middle of DRAIN
        @(negedge CLK);
        nRST = 1'b1;
        halt_mem = 1'b1;
        @(posedge CLK);
        #1;
        halt_mem = 1'b0;
        chk("drain entry state", 32'(state), 32'd3);
        @(negedge CLK);
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        chk("mid-drain reset state", 32'(state), 32'd0);
        chk("mid-drain reset enables",
            32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'h1f);
        chk_counters("mid-drain reset");
        $display("reset mid-DRAIN state=%0d", state);

        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        chk("post-reset run state", 32'(state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of performance counters.
REQ-002 SHALL have parameter: DRAIN, 2, cycles between halt leaving MEM and halt_out assertion.
REQ-003 SHALL have ports: CLK  in  1  clock, rising edge; nRST  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: ihit  in  1  fetch word valid; dhit  in  1  data access done; ex_memop  in  1  EX/MEM latch memRen|memWen.
REQ-005 SHALL have ports: idex_memren  in  1; idex_regdest  in  5; ifid_rs  in  5; ifid_rt  in  5  load-use inputs.
REQ-006 SHALL have ports: br_mispredict  in  1  MEM-stage branch resolution differs from BTB prediction; jump  in  1  decode redirect (j/jal/jr); halt_mem  in  1  halt in EX/MEM latch.
REQ-007 SHALL have ports: pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  latch enables; ifid_flush, idex_flush, exmem_flush  out  1  latch clears; halt_out  out  1; state  out  3.
REQ-008 SHALL have ports: stall_cnt, flush_cnt  out  CNT_W  performance counters.

Function
REQ-009 SHALL implement FSM states RUN=0, DWAIT=1, FLUSH=2, DRAIN=3, HALTED=4, driven on the state port.
REQ-010 SHALL compute adv = ihit & (~ex_memop | dhit) each cycle; pipeline advances only when adv=1.
REQ-011 RUN, adv=1, no hazard: all five enables 1, all flushes 0.
REQ-012 RUN/DWAIT, ex_memop=1 & dhit=0: all enables 0, next state DWAIT; DWAIT exits to RUN on the cycle dhit=1 with adv=1, with that cycle's enables per REQ-011.
REQ-013 ihit=0 with adv=0 outside DWAIT: all enables 0, state unchanged; no flush asserted.
REQ-014 Load-use (idex_memren & idex_regdest!=0 & idex_regdest in {ifid_rs, ifid_rt}) with adv=1: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; stall lasts exactly one cycle.
REQ-015 br_mispredict with adv=1: all enables 1, ifid_flush=idex_flush=exmem_flush=1, next state FLUSH; priority over load-use and jump.
REQ-016 FLUSH: one cycle, enables per adv, load-use detection suppressed, then RUN; if adv=0 remain in FLUSH.
REQ-017 jump with adv=1 and no mispredict: ifid_flush=1 only, all enables 1.
REQ-018 halt_mem with adv=1: memwb_en=1, pc_en=0, all three flushes 1, load counter=DRAIN, next DRAIN; priority over br_mispredict.
REQ-019 DRAIN: pc_en=ifid_en=idex_en=exmem_en=0, memwb_en=1, counter decrements; at counter=1 next state HALTED.
REQ-020 HALTED: all enables 0, flushes 0, halt_out=1; exit only by reset.
REQ-021 Flush and enable SHALL never both request opposite actions: flush dominates enable in the latch.

Reset
REQ-022 nRST=0 at a rising CLK edge: state=RUN, drain counter=0, halt_out=0, stall_cnt=flush_cnt=0; nRST overrides every other input including mid-DRAIN or HALTED.
REQ-023 Enables and flushes SHALL be combinational from state and inputs; after reset they follow REQ-011.

Configuration
REQ-024 Macro PIPELINE_CTRL_PERF_CNT_EN defined: stall_cnt increments on any cycle with pc_en=0 outside HALTED; flush_cnt increments on any cycle with any flush=1; both saturate at all-ones.
REQ-025 Macro PIPELINE_CTRL_PERF_CNT_EN undefined: no counter registers; stall_cnt and flush_cnt tied to 0.

Verification
REQ-026 Reset then ihit=1, no hazards 10 cycles -> state=0, all enables 1, flushes 0, halt_out=0.
REQ-027 ex_memop=1, dhit=0 for 3 cycles, then dhit=1 -> state=1 three cycles, enables 0, then RUN with enables 1; stall_cnt=3 (macro on).
REQ-028 idex_memren=1, idex_regdest=5, ifid_rt=5 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; regdest=0 same case -> no stall.
REQ-029 br_mispredict=1 and load-use same cycle, adv=1 -> three flushes 1, pc_en=1, next state FLUSH then RUN; flush_cnt=1.
REQ-030 halt_mem=1, DRAIN=2 -> state 3 for two cycles, memwb_en=1, then state 4, halt_out=1; nRST=0 in HALTED -> state 0, counters 0.
